// File: rtl/hazard_ctrl.sv
// hazard_ctrl: IF/ID stall/flush, PC enable, ID/EX bubble and pipeline freeze
// for the 5-stage CPU. It resolves a multi-cycle data-memory handshake first,
// then load-use hazards, then taken branches.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_RUN  | no outstanding data-memory access
// S_WAIT | access outstanding; pipeline frozen until ack or timeout
module hazard_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             id_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_write,
    output logic             IFstall,
    output logic             IFflush,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    localparam logic [7:0]       TMO      = 8'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [0:0]       state_q, state_d;
    logic [7:0]       tmr_q, tmr_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic freeze;
    logic load_use;
    logic timed_out;

    assign timed_out = (state_q == S_WAIT) && !mem_ack && (tmr_q == TMO);

    // Freeze term: a request without a same-cycle ack, or an outstanding wait
    // that has neither been acked nor reached the timeout.
    always_comb begin
        freeze = 1'b0;
        if (state_q == S_RUN) begin
            freeze = mem_req && !mem_ack;
        end else begin
            freeze = !mem_ack && (tmr_q != TMO);
        end
    end

    // Load-use term: a load in EX writing a register the ID instruction reads.
    // Register 0 is hard-wired zero so it never creates a hazard.
    always_comb begin
        load_use = ex_memread && (ex_rd != 5'd0) &&
                   ((id_use_rs && (id_rs == ex_rd)) ||
                    (id_use_rt && (id_rt == ex_rd)));
    end

    // Control decode, priority rst > freeze > load-use > branch.
    always_comb begin
        pc_write    = 1'b1;
        IFstall     = 1'b0;
        IFflush     = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        if (rst) begin
            pc_write = 1'b0;
            IFflush  = 1'b1;
        end else if (freeze) begin
            pc_write    = 1'b0;
            IFstall     = 1'b1;
            pipe_freeze = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            IFstall     = 1'b1;
            idex_bubble = 1'b1;
        end else if (id_branch_taken) begin
            IFflush = 1'b1;
        end
    end

    // Wait FSM and timer; new requests are ignored while a wait is outstanding.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        mem_err_d = mem_err_q;
        case (state_q)
            S_RUN: begin
                if (mem_req && !mem_ack) begin
                    state_d = S_WAIT;
                    tmr_d   = 8'd1;
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    state_d = S_RUN;
                    tmr_d   = 8'd0;
                end else if (timed_out) begin
                    state_d   = S_RUN;
                    tmr_d     = 8'd0;
                    mem_err_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            default: begin
                state_d = S_RUN;
                tmr_d   = 8'd0;
            end
        endcase
    end

    // Saturating performance counters; the reset cycle is never counted
    // because the registers are cleared in that cycle anyway.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (IFstall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (IFflush && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            tmr_q       <= 8'd0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Each test pushes the expected control
// vector {pc_write, IFstall, IFflush, idex_bubble, pipe_freeze} when it drives
// a cycle and pops it when the outputs are sampled on the falling edge.
module tb_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;

    localparam logic [4:0] NRM = 5'b10000;
    localparam logic [4:0] LU  = 5'b01010;
    localparam logic [4:0] BR  = 5'b10100;
    localparam logic [4:0] FRZ = 5'b01001;
    localparam logic [4:0] RST = 5'b00100;

    // stimulus bits {rst, ld, br, req, ack}
    localparam logic [4:0] I_IDLE = 5'b00000;
    localparam logic [4:0] I_RST  = 5'b10000;
    localparam logic [4:0] I_LD   = 5'b01000;
    localparam logic [4:0] I_BR   = 5'b00100;
    localparam logic [4:0] I_REQ  = 5'b00010;
    localparam logic [4:0] I_ACK  = 5'b00001;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs, id_rt, ex_rd;
    logic             id_use_rs, id_use_rt, ex_memread;
    logic             id_branch_taken, mem_req, mem_ack;
    logic             pc_write, IFstall, IFflush, idex_bubble, pipe_freeze, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [4:0]       ctl;

    int n_tests = 0;
    int n_fail  = 0;

    logic [4:0] sb[$];
    logic [4:0] ld_rd   = 5'd5;
    int         use_sel = 0;

    always #5 clk = ~clk;

    assign ctl = {pc_write, IFstall, IFflush, idex_bubble, pipe_freeze};

    hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_memread(ex_memread), .ex_rd(ex_rd),
        .id_branch_taken(id_branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_write(pc_write), .IFstall(IFstall), .IFflush(IFflush),
        .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic drive(input logic [4:0] s, input logic [4:0] e);
        rst             = s[4];
        ex_memread      = s[3];
        ex_rd           = ld_rd;
        id_branch_taken = s[2];
        mem_req         = s[1];
        mem_ack         = s[0];
        case (use_sel)
            1: begin id_rs = 5'd30;  id_rt = ld_rd; id_use_rs = 1'b1; id_use_rt = 1'b1; end
            2: begin id_rs = ld_rd;  id_rt = ld_rd; id_use_rs = 1'b0; id_use_rt = 1'b0; end
            default: begin id_rs = ld_rd; id_rt = 5'd31; id_use_rs = 1'b1; id_use_rt = 1'b0; end
        endcase
        sb.push_back(e);
    endtask

    task automatic test_reset();
        logic [4:0] e;
        drive(I_RST, RST);
        @(negedge clk);
        e = sb.pop_front();
        n_tests++;
        if (ctl !== e) begin n_fail++; $display("FAIL reset_ctl got=%b exp=%b", ctl, e); end
        @(posedge clk); #1;
        n_tests++;
        if ({mem_err, stall_cnt, flush_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs got err=%b stall=%0d flush=%0d exp 0/0/0", mem_err, stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_load_use();
        logic [4:0] st[$];
        logic [4:0] ex[$];
        logic [4:0] e;
        int         sel[$];
        logic [4:0] rd[$];
        st  = '{I_RST, I_LD, I_IDLE, I_LD, I_LD,  I_LD, I_LD | I_BR};
        ex  = '{RST,   LU,   NRM,    NRM,  LU,    NRM,  LU};
        sel = '{0,     0,    0,      0,    1,     2,    0};
        rd  = '{5'd5,  5'd5, 5'd5,   5'd0, 5'd5,  5'd5, 5'd9};
        for (int i = 0; i < st.size(); i++) begin
            use_sel = sel[i];
            ld_rd   = rd[i];
            drive(st[i], ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_tests++;
            if (ctl !== e) begin n_fail++; $display("FAIL load_use[%0d] got=%b exp=%b", i, ctl, e); end
            @(posedge clk); #1;
            if (i == 2) begin
                n_tests++;
                if (stall_cnt !== 4'd1) begin n_fail++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
            end
        end
        use_sel = 0;
        ld_rd   = 5'd5;
        n_tests++;
        if (stall_cnt !== 4'd3 || flush_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL lu_counts got stall=%0d flush=%0d exp 3/0", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_branch();
        logic [4:0] st[$];
        logic [4:0] ex[$];
        logic [4:0] e;
        st = '{I_RST, I_BR, I_IDLE};
        ex = '{RST,   BR,   NRM};
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_tests++;
            if (ctl !== e) begin n_fail++; $display("FAIL branch[%0d] got=%b exp=%b", i, ctl, e); end
            @(posedge clk); #1;
        end
        n_tests++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL br_counts got flush=%0d stall=%0d exp 1/0", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_mem_wait();
        logic [4:0] st[$];
        logic [4:0] ex[$];
        logic [4:0] e;
        st = '{I_RST, I_REQ, I_BR, I_BR | I_REQ, I_BR | I_ACK, I_IDLE, I_REQ | I_ACK, I_IDLE, I_ACK};
        ex = '{RST,   FRZ,   FRZ,  FRZ,          BR,           NRM,    NRM,           NRM,    NRM};
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_tests++;
            if (ctl !== e) begin n_fail++; $display("FAIL mem_wait[%0d] got=%b exp=%b", i, ctl, e); end
            @(posedge clk); #1;
        end
        n_tests++;
        if (stall_cnt !== 4'd3 || flush_cnt !== 4'd1 || mem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mw_counts got stall=%0d flush=%0d err=%b exp 3/1/0", stall_cnt, flush_cnt, mem_err);
        end
    endtask

    task automatic test_timeout();
        logic [4:0] st[$];
        logic [4:0] ex[$];
        logic       er[$];
        logic [4:0] e;
        logic       ee;
        st = '{I_RST, I_REQ, I_IDLE, I_IDLE, I_IDLE, I_IDLE, I_IDLE, I_ACK, I_REQ | I_ACK, I_RST, I_IDLE};
        ex = '{RST,   FRZ,   FRZ,    FRZ,    FRZ,    NRM,    NRM,    NRM,   NRM,           RST,   NRM};
        er = '{1'b0,  1'b0,  1'b0,   1'b0,   1'b0,   1'b0,   1'b1,   1'b1,  1'b1,          1'b1,  1'b0};
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            e  = sb.pop_front();
            ee = er[i];
            n_tests++;
            if (ctl !== e || mem_err !== ee) begin
                n_fail++;
                $display("FAIL timeout[%0d] got ctl=%b err=%b exp ctl=%b err=%b", i, ctl, mem_err, e, ee);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        logic [4:0] st[$];
        logic [4:0] ex[$];
        logic [4:0] e;
        st.push_back(I_RST); ex.push_back(RST);
        for (int k = 0; k < 20; k++) begin st.push_back(I_LD); ex.push_back(LU); end
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_tests++;
            if (ctl !== e) begin n_fail++; $display("FAIL sat[%0d] got=%b exp=%b", i, ctl, e); end
            @(posedge clk); #1;
            if (i == 15 || i == 20) begin
                n_tests++;
                if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_cnt[%0d] got=%0d exp=15", i, stall_cnt); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] st[$];
        logic [4:0] ex[$];
        logic [4:0] e;
        st = '{I_REQ | I_LD, I_LD, I_RST, I_ACK, I_IDLE, I_LD | I_BR, I_BR};
        ex = '{FRZ,          FRZ,  RST,   NRM,   NRM,    LU,          BR};
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_tests++;
            if (ctl !== e) begin n_fail++; $display("FAIL b2b[%0d] got=%b exp=%b", i, ctl, e); end
            @(posedge clk); #1;
            if (i == 2) begin
                n_tests++;
                if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
                    n_fail++;
                    $display("FAIL b2b_rst_cnt got stall=%0d flush=%0d exp 0/0", stall_cnt, flush_cnt);
                end
            end
        end
        n_tests++;
        if (stall_cnt !== 4'd1 || flush_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL b2b_counts got stall=%0d flush=%0d exp 1/1", stall_cnt, flush_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        ex_memread = 1'b0; ex_rd = '0; id_branch_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
